// File: rtl/ex.sv
// MIPS execute stage: registered logic results plus a 32-cycle restoring divider
// that stalls the front of the pipeline while it iterates.
module ex (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_data_i,
    input  logic [31:0] reg2_data_i,
    input  logic [4:0]  w_addr_i,
    input  logic        wreg_i,
    output logic [4:0]  w_addr_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallreq_o
);

    localparam logic [7:0] EXE_AND_OP    = 8'h24;
    localparam logic [7:0] EXE_OR_OP     = 8'h25;
    localparam logic [7:0] EXE_XOR_OP    = 8'h26;
    localparam logic [7:0] EXE_NOR_OP    = 8'h27;
    localparam logic [7:0] EXE_DIV_OP    = 8'h1A;
    localparam logic [7:0] EXE_DIVU_OP   = 8'h1B;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [4:0] NOP_REG_ADDR  = 5'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV_ZERO,
        S_DIV_ON,
        S_DIV_END
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [5:0]  r_cnt;
    logic [31:0] r_rem;
    logic [31:0] r_quot;
    logic [31:0] r_divisor;
    logic        r_sign1;
    logic        r_sign2;

    logic        w_is_div;
    logic        w_signed;
    logic        w_start;
    logic [31:0] w_op1_abs;
    logic [31:0] w_op2_abs;
    logic [32:0] w_shift;
    logic        w_ge;
    logic [31:0] w_rem_next;
    logic [31:0] w_div_q;
    logic [31:0] w_div_r;
    logic [31:0] w_logic_res;

    assign w_is_div  = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
    assign w_signed  = (aluop_i == EXE_DIV_OP);
    assign w_start   = (r_state == S_IDLE) && w_is_div && !flush_i;
    assign w_op1_abs = (w_signed && reg1_data_i[31]) ? (~reg1_data_i + 32'd1) : reg1_data_i;
    assign w_op2_abs = (w_signed && reg2_data_i[31]) ? (~reg2_data_i + 32'd1) : reg2_data_i;

    assign stallreq_o = !rst && !flush_i &&
                        (w_start || (r_state == S_DIV_ON) || (r_state == S_DIV_ZERO));

    // Dividend shifts out of r_quot's MSB while quotient bits shift in at the LSB.
    assign w_shift    = {r_rem, r_quot[31]};
    assign w_ge       = (w_shift >= {1'b0, r_divisor});
    assign w_rem_next = w_ge ? (w_shift[31:0] - r_divisor) : w_shift[31:0];

    assign w_div_q = (r_sign1 ^ r_sign2) ? (~r_quot + 32'd1) : r_quot;
    assign w_div_r = r_sign1 ? (~r_rem + 32'd1) : r_rem;

    always_comb begin
        // NOTE: default first so every path assigns w_logic_res and no latch is inferred.
        w_logic_res = 32'd0;
        if (alusel_i == EXE_RES_LOGIC) begin
            case (aluop_i)
                EXE_AND_OP: w_logic_res = reg1_data_i & reg2_data_i;
                EXE_OR_OP:  w_logic_res = reg1_data_i | reg2_data_i;
                EXE_XOR_OP: w_logic_res = reg1_data_i ^ reg2_data_i;
                EXE_NOR_OP: w_logic_res = ~(reg1_data_i | reg2_data_i);
                default:    w_logic_res = 32'd0;
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (flush_i) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:     if (w_start) w_next_state = (reg2_data_i == 32'd0) ? S_DIV_ZERO : S_DIV_ON;
                S_DIV_ZERO: w_next_state = S_DIV_END;
                S_DIV_ON:   if (r_cnt == 6'd31) w_next_state = S_DIV_END;
                S_DIV_END:  w_next_state = S_IDLE;
                default:    w_next_state = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // NOTE: divider datapath is reset too, so no stale operand can leak after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= 6'd0;
            r_rem     <= 32'd0;
            r_quot    <= 32'd0;
            r_divisor <= 32'd0;
            r_sign1   <= 1'b0;
            r_sign2   <= 1'b0;
        end else if (!flush_i) begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_cnt     <= 6'd0;
                        r_rem     <= 32'd0;
                        r_quot    <= w_op1_abs;
                        r_divisor <= w_op2_abs;
                        r_sign1   <= w_signed & reg1_data_i[31];
                        r_sign2   <= w_signed & reg2_data_i[31];
                    end
                end
                S_DIV_ON: begin
                    r_cnt  <= r_cnt + 6'd1;
                    r_rem  <= w_rem_next;
                    r_quot <= {r_quot[30:0], w_ge};
                end
                S_DIV_ZERO: begin
                    r_rem  <= r_quot;
                    r_quot <= 32'hFFFF_FFFF;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_addr_o <= NOP_REG_ADDR;
            wreg_o   <= 1'b0;
            wdata_o  <= 32'd0;
            whilo_o  <= 1'b0;
            hi_o     <= 32'd0;
            lo_o     <= 32'd0;
        end else if (flush_i || stallreq_o) begin
            w_addr_o <= NOP_REG_ADDR;
            wreg_o   <= 1'b0;
            wdata_o  <= 32'd0;
            whilo_o  <= 1'b0;
            hi_o     <= 32'd0;
            lo_o     <= 32'd0;
        end else if (r_state == S_DIV_END) begin
            w_addr_o <= w_addr_i;
            wreg_o   <= 1'b0;
            wdata_o  <= 32'd0;
            whilo_o  <= 1'b1;
            hi_o     <= w_div_r;
            lo_o     <= w_div_q;
        end else begin
            w_addr_o <= w_addr_i;
            wreg_o   <= wreg_i;
            wdata_o  <= w_logic_res;
            whilo_o  <= 1'b0;
            hi_o     <= 32'd0;
            lo_o     <= 32'd0;
        end
    end

endmodule

// File: tb/tb_ex.sv
// Self-checking bench for ex: directed cases plus randomized logic/divide traffic
// compared against an arithmetic reference model.
module tb_ex;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_data_i;
    logic [31:0] reg2_data_i;
    logic [4:0]  w_addr_i;
    logic        wreg_i;
    logic [4:0]  w_addr_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        whilo_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        stallreq_o;

    int n_checks = 0;
    int n_errors = 0;

    ex dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .aluop_i     (aluop_i),
        .alusel_i    (alusel_i),
        .reg1_data_i (reg1_data_i),
        .reg2_data_i (reg2_data_i),
        .w_addr_i    (w_addr_i),
        .wreg_i      (wreg_i),
        .w_addr_o    (w_addr_o),
        .wreg_o      (wreg_o),
        .wdata_o     (wdata_o),
        .whilo_o     (whilo_o),
        .hi_o        (hi_o),
        .lo_o        (lo_o),
        .stallreq_o  (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_nop();
        aluop_i     = 8'h00;
        alusel_i    = 3'b000;
        reg1_data_i = 32'd0;
        reg2_data_i = 32'd0;
        w_addr_i    = 5'd0;
        wreg_i      = 1'b0;
    endtask

    // Reference model: logic class result straight from the operation table.
    function automatic logic [31:0] logic_model(input logic [7:0] op, input logic [2:0] sel,
                                                input logic [31:0] a, input logic [31:0] b);
        if (sel != 3'b001) return 32'd0;
        case (op)
            8'h24:   return a & b;
            8'h25:   return a | b;
            8'h26:   return a ^ b;
            8'h27:   return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    // Reference model: divide on magnitudes with / and %, then sign fix-up.
    task automatic div_model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] q, output logic [31:0] r);
        logic [31:0] ua;
        logic [31:0] ub;
        logic        s1;
        logic        s2;
        s1 = sgn && a[31];
        s2 = sgn && b[31];
        ua = s1 ? 32'd0 - a : a;
        ub = s2 ? 32'd0 - b : b;
        if (ub == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = ua;
        end else begin
            q = ua / ub;
            r = ua % ub;
        end
        if (s1 ^ s2) q = 32'd0 - q;
        if (s1)      r = 32'd0 - r;
    endtask

    task automatic run_logic(input string tag, input logic [7:0] op, input logic [2:0] sel,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] addr, input logic we);
        aluop_i = op; alusel_i = sel; reg1_data_i = a; reg2_data_i = b;
        w_addr_i = addr; wreg_i = we;
        #1;
        check({tag, ".stall"}, 32'(stallreq_o), 32'd0);
        step();
        check({tag, ".wdata"}, wdata_o, logic_model(op, sel, a, b));
        check({tag, ".wreg"},  32'(wreg_o), 32'(we));
        check({tag, ".waddr"}, 32'(w_addr_o), 32'(addr));
        check({tag, ".whilo"}, 32'(whilo_o), 32'd0);
    endtask

    task automatic run_div(input string tag, input logic sgn,
                           input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        int          cycles;
        div_model(sgn, a, b, q, r);
        aluop_i = sgn ? 8'h1A : 8'h1B; alusel_i = 3'b000;
        reg1_data_i = a; reg2_data_i = b; w_addr_i = 5'd0; wreg_i = 1'b0;
        #1;
        cycles = 0;
        while (stallreq_o && cycles < 100) begin
            step();
            cycles++;
        end
        check({tag, ".stall_cycles"}, 32'(cycles), (b == 32'd0) ? 32'd2 : 32'd33);
        check({tag, ".no_early_whilo"}, 32'(whilo_o), 32'd0);
        step();
        drive_nop();
        check({tag, ".lo"},    lo_o, q);
        check({tag, ".hi"},    hi_o, r);
        check({tag, ".whilo"}, 32'(whilo_o), 32'd1);
        check({tag, ".wreg"},  32'(wreg_o), 32'd0);
        check({tag, ".wdata"}, wdata_o, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  ops [4];
        int          seen_whilo;
        ops = '{8'h24, 8'h25, 8'h26, 8'h27};

        rst = 1'b1;
        flush_i = 1'b0;
        drive_nop();
        step();
        step();
        check("reset.wdata", wdata_o, 32'd0);
        check("reset.waddr", 32'(w_addr_o), 32'd0);
        check("reset.whilo", 32'(whilo_o), 32'd0);
        check("reset.hilo",  hi_o | lo_o, 32'd0);
        check("reset.stall", 32'(stallreq_o), 32'd0);
        rst = 1'b0;
        step();

        run_logic("or_basic", 8'h25, 3'b001, 32'h0000_1100, 32'h0000_0011, 5'd5, 1'b1);
        run_logic("and_ff",   8'h24, 3'b001, 32'hF0F0_FFFF, 32'hFF00_00FF, 5'd31, 1'b1);
        run_logic("nor_zero", 8'h27, 3'b001, 32'd0, 32'd0, 5'd1, 1'b0);
        run_logic("nop_cls",  8'h26, 3'b000, 32'hDEAD_BEEF, 32'h1234_5678, 5'd7, 1'b1);

        run_div("divu_100_7",   1'b0, 32'd100, 32'd7);
        run_div("div_m7_2",     1'b1, 32'hFFFF_FFF9, 32'd2);
        run_div("divu_by_zero", 1'b0, 32'h0000_1234, 32'd0);
        run_div("div_neg_zero", 1'b1, 32'hFFFF_FF00, 32'd0);
        run_div("div_minint",   1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_div("divu_max_1",   1'b0, 32'hFFFF_FFFF, 32'd1);

        // Flush a running DIVU in its 10th cycle; the following OR must run untouched.
        aluop_i = 8'h1B; alusel_i = 3'b000; reg1_data_i = 32'd100; reg2_data_i = 32'd7;
        w_addr_i = 5'd0; wreg_i = 1'b0;
        for (int i = 0; i < 10; i++) step();
        flush_i = 1'b1;
        #1;
        check("flush.stall", 32'(stallreq_o), 32'd0);
        step();
        flush_i = 1'b0;
        check("flush.bubble", 32'(whilo_o) | wdata_o | lo_o | hi_o, 32'd0);
        run_logic("flush.or", 8'h25, 3'b001, 32'h0000_1100, 32'h0000_0011, 5'd5, 1'b1);
        drive_nop();
        seen_whilo = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (whilo_o) seen_whilo++;
        end
        check("flush.no_whilo", 32'(seen_whilo), 32'd0);

        // Reset in the middle of a signed divide.
        aluop_i = 8'h1A; alusel_i = 3'b000; reg1_data_i = 32'd1000; reg2_data_i = 32'd9;
        for (int i = 0; i < 15; i++) step();
        rst = 1'b1;
        #1;
        check("rst_mid.stall", 32'(stallreq_o), 32'd0);
        check("rst_mid.out", 32'(whilo_o) | wdata_o | lo_o | hi_o | 32'(wreg_o), 32'd0);
        step();
        rst = 1'b0;
        drive_nop();
        step();
        run_div("rst_mid.divu_9_3", 1'b0, 32'd9, 32'd3);

        for (int n = 0; n < 40; n++) begin
            int          kind;
            logic [31:0] a;
            logic [31:0] b;
            kind = $urandom_range(0, 9);
            a = $urandom();
            b = $urandom();
            if (kind <= 3) begin
                run_logic("rnd_logic", ops[kind], 3'b001, a, b, 5'($urandom()), 1'($urandom()));
            end else if (kind == 4) begin
                run_logic("rnd_badop", 8'h20, 3'b001, a, b, 5'($urandom()), 1'b1);
            end else if (kind == 5) begin
                run_logic("rnd_badsel", 8'h25, 3'b111, a, b, 5'($urandom()), 1'b1);
            end else begin
                case ($urandom_range(0, 3))
                    0:       b = 32'd0;
                    1:       b = 32'($urandom_range(1, 15));
                    2:       b = 32'($urandom_range(0, 15)) - 32'd8;
                    default: ;
                endcase
                run_div((kind >= 8) ? "rnd_div" : "rnd_divu", kind >= 8, a, b);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
